// File: rtl/dispatch_buffer_pkg.sv
// Types shared along the decode -> dispatch -> rename path, plus the
// machine width used by every block on that path.
`ifndef N_WAY
`define N_WAY 2
`endif

package dispatch_buffer_pkg;

    localparam int ARCH_REG_W = 5;

    typedef struct packed {
        logic [ARCH_REG_W-1:0] src1;
        logic [ARCH_REG_W-1:0] src2;
        logic [ARCH_REG_W-1:0] dest;
        logic                  valid;
    } DISPATCH_PACKET;

    typedef struct packed {
        DISPATCH_PACKET pkt;
        logic           branch;
    } IB_ENTRY;

    localparam int N_WAY_DEFAULT = `N_WAY;

endpackage

// File: rtl/leading_ones_cnt.sv
// Counts consecutive set bits starting at bit 0, i.e. the run of
// accepted/valid slots beginning with the oldest one.
module leading_ones_cnt #(
    parameter int W = 2
) (
    input  logic [W-1:0]       i_bits,
    output logic [$clog2(W):0] o_count
);

    localparam int CW = $clog2(W) + 1;

    logic w_run;

    always_comb begin
        o_count = '0;
        w_run   = 1'b1;
        for (int i = 0; i < W; i++) begin
            w_run   = w_run & i_bits[i];
            o_count = o_count + CW'(w_run);
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order circular instruction buffer between decode and rename.
// Presents the oldest N_WAY entries each cycle and retires the accepted prefix.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int IB_DEPTH = 8,
    parameter int N_WAY    = `N_WAY
) (
    input  logic                      clock,
    input  logic                      reset,
    input  DISPATCH_PACKET            decode_packet [N_WAY],
    input  logic [N_WAY-1:0]          decode_branch,
    output logic [$clog2(N_WAY):0]    decode_ready_num,
    output DISPATCH_PACKET            dispatch_packet [N_WAY],
    output logic [N_WAY-1:0]          branch_inst,
    output logic [$clog2(N_WAY):0]    dispatch_num,
    input  logic [N_WAY-1:0]          dispatched,
    input  logic                      branch_haz,
    output logic [$clog2(IB_DEPTH):0] ib_count
);

    localparam int PTR_W = $clog2(IB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NUM_W = $clog2(N_WAY) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IB_DEPTH);
    localparam logic [CNT_W-1:0] NWAY_C  = CNT_W'(N_WAY);

    IB_ENTRY          r_entries [IB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_ready;
    logic [CNT_W-1:0] w_avail;
    logic [N_WAY-1:0] w_dec_valid;
    logic [NUM_W-1:0] w_pop_lead;
    logic [NUM_W-1:0] w_enq_lead;
    logic [NUM_W-1:0] w_pop;
    logic [NUM_W-1:0] w_enq;

    // Handshake: decode may fill decode_ready_num leading slots and rename
    // accepts a leading prefix of the dispatch_num presented slots via
    // `dispatched`; both take effect at the same edge, and freed slots are
    // only offered to decode from the following cycle.
    assign w_free           = DEPTH_C - r_count;
    assign w_ready          = (w_free < NWAY_C) ? w_free : NWAY_C;
    assign w_avail          = (r_count < NWAY_C) ? r_count : NWAY_C;
    assign decode_ready_num = NUM_W'(w_ready);
    assign dispatch_num     = NUM_W'(w_avail);
    assign ib_count         = r_count;

    for (genvar g = 0; g < N_WAY; g++) begin : g_slot
        IB_ENTRY w_ent;
        logic    w_live;

        assign w_ent  = r_entries[r_head + PTR_W'(g)];
        assign w_live = (CNT_W'(g) < r_count) && w_ent.pkt.valid;
        assign dispatch_packet[g] = '{src1:  w_ent.pkt.src1,
                                      src2:  w_ent.pkt.src2,
                                      dest:  w_ent.pkt.dest,
                                      valid: w_live};
        assign branch_inst[g] = w_live & w_ent.branch;
        assign w_dec_valid[g] = decode_packet[g].valid;
    end

    leading_ones_cnt #(.W(N_WAY)) u_pop_lead (
        .i_bits  (dispatched),
        .o_count (w_pop_lead)
    );

    leading_ones_cnt #(.W(N_WAY)) u_enq_lead (
        .i_bits  (w_dec_valid),
        .o_count (w_enq_lead)
    );

    assign w_pop = (w_pop_lead < dispatch_num)     ? w_pop_lead : dispatch_num;
    assign w_enq = (w_enq_lead < decode_ready_num) ? w_enq_lead : decode_ready_num;

    always_ff @(posedge clock) begin
        if (!reset || branch_haz) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_enq);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: r_count alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (reset && !branch_haz) begin
            for (int i = 0; i < N_WAY; i++) begin
                if (NUM_W'(i) < w_enq) begin
                    r_entries[r_tail + PTR_W'(i)] <= '{pkt: decode_packet[i], branch: decode_branch[i]};
                end
            end
        end
    end

endmodule
